// File: rtl/division_con_signo.sv
// division_con_signo: sequential signed integer divider (restoring, magnitude based).
// Truncated quotient Q and remainder R; R carries the dividend's sign.
// Handshake: valid sampled in IDLE, one-cycle done pulse, busy while computing.
// Optional build macro DIVISION_CON_SIGNO_EARLY_EXIT_EN: when |A| < |B| (B != 0)
// the result Q=0, R=A is produced directly from IDLE with 1-cycle latency.
module division_con_signo #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic [2:0]   state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] mag_b_q, mag_b_d;
  logic         sa_q, sa_d;
  logic         sb_q, sb_d;
  logic [N:0]   rem_q, rem_d;
  logic [N-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] r_q, r_d;
  logic         dz_q, dz_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] abs_a;
  logic [N-1:0] abs_b;
  logic [N+1:0] trial;

  // Operand magnitudes; |-2^(N-1)| wraps to 2^(N-1), which is correct as unsigned.
  always_comb begin
    abs_a = A[N-1] ? ('0 - A) : A;
    abs_b = B[N-1] ? ('0 - B) : B;
    trial = {1'b0, rem_q} - {2'b00, mag_b_q};
  end

  // Next-state and datapath control for the shift/subtract FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_b_d = mag_b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          a_d     = A;
          b_d     = B;
          sa_d    = A[N-1];
          sb_d    = B[N-1];
          mag_b_d = abs_b;
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end
`ifdef DIVISION_CON_SIGNO_EARLY_EXIT_EN
          else if (abs_a < abs_b) begin
            q_d     = '0;
            r_d     = A;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end
`endif
          else begin
            rem_d   = '0;
            quo_d   = abs_a;
            cnt_d   = CW'(N);
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        rem_d   = {rem_q[N-1:0], quo_q[N-1]};
        quo_d   = {quo_q[N-2:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        if (!trial[N+1]) begin
          rem_d    = trial[N:0];
          quo_d[0] = 1'b1;
        end else begin
          quo_d[0] = 1'b0;
        end
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? S_FIX : S_SHIFT;
      end
      S_FIX: begin
        q_d     = (sa_q ^ sb_q) ? ('0 - quo_q) : quo_q;
        r_d     = sa_q ? ('0 - rem_q[N-1:0]) : rem_q[N-1:0];
        ovf_d   = (a_q == MIN_NEG) && (b_q == '1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_b_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_b_q <= mag_b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dz_q;
  assign ovf         = ovf_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_SHIFT) || (state_q == S_SUB) || (state_q == S_FIX);

endmodule

// File: doc/division_con_signo.md
Name: division_con_signo

Overview:
- Sequential signed integer divider; the inverse operation of the team's Booth signed multiplier.
- Uses the same valid/done handshake and the same operand naming: A is the dividend, B is the divisor.
- Computes the truncated quotient Q and remainder R with an explicit FSM using restoring shift/subtract on magnitudes, followed by a sign fix.
- Sits beside the multiplier in the arithmetic datapath and is driven by the same top-level controller.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid  input  1  start request; sampled only in IDLE.
- A  input  N  signed dividend (two's complement).
- B  input  N  signed divisor (two's complement).
- Q  output  N  signed quotient, registered.
- R  output  N  signed remainder, registered.
- done  output  1  one-cycle pulse; Q/R/flags valid from this cycle onward.
- busy  output  1  high from the cycle after valid is accepted until done is asserted.
- div_by_zero  output  1  registered; set when B==0 for the completed operation.
- ovf  output  1  registered; set for the -2^(N-1) / -1 case.

Behaviour:
- Reset values: Q=0, R=0, done=0, busy=0, div_by_zero=0, ovf=0. Internal state: FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately to IDLE. No done pulse is produced for the aborted operation.
- Operand capture:
  - Internal registers hold unsigned magnitudes |A| and |B| (N bits each), sA=A[N-1], sB=B[N-1], rem (N+1 bits), quo (N bits), count (clog2(N+1) bits).
  - |-2^(N-1)| = 2^(N-1) is representable as an unsigned N-bit value.
- FSM states:
  - IDLE: busy=0.
    - On valid=1: latch A, B, signs and magnitudes.
    - If B==0: load Q={N{1}}, R=A, div_by_zero=1, ovf=0; go to DONE.
    - Else: rem=0, quo=|A|, count=N, clear flags; go to SHIFT.
    - valid=0: stay.
  - SHIFT: {rem,quo} <<= 1; go to SUB.
  - SUB: trial = rem - |B| at N+1 bits.
    - trial >= 0: rem=trial, quo[0]=1.
    - trial < 0: rem unchanged, quo[0]=0.
    - count-=1. If count becomes 0 go to FIX, else go to SHIFT.
  - FIX:
    - Q = (sA^sB) ? -quo : quo, truncated to N bits.
    - R = sA ? -rem[N-1:0] : rem[N-1:0]; the remainder takes the dividend's sign.
    - ovf = (A==-2^(N-1) && B==-1), giving Q=-2^(N-1) (wrapped) and R=0.
    - Go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- busy is 1 in SHIFT, SUB and FIX; 0 in IDLE and DONE.
- Latency, counted from the edge that samples valid to the cycle in which done=1:
  - Normal path: 2N+2 cycles (18 for N=8).
  - Zero-divisor path: 1 cycle.
- Q, R, div_by_zero and ovf hold their values until the next accepted operation loads them. They never change while done=0 and the FSM is in IDLE.
- valid while not IDLE: ignored; no queuing.
- valid held high continuously: a new operation starts in the IDLE cycle following DONE.
- Back-to-back throughput: one operation per 2N+3 cycles.
- A and B may change after the accept edge without affecting the result.

Optional Feature:
- Macro: DIVISION_CON_SIGNO_EARLY_EXIT_EN.
- When defined, IDLE additionally checks |A| < |B| with B != 0. In that case it loads Q=0, R=A, with both flags 0, and goes directly to DONE, giving 1-cycle latency.
- Without the macro, these operands take the full 2N+2-cycle path with identical Q/R results.
- The zero-divisor shortcut exists in both builds.

Test Plan:
- A=0x64 (100), B=0x07 -> Q=0x0E (14), R=0x02, flags 0; done exactly 18 cycles after the accept edge; busy high 17 cycles.
- A=0x9C (-100), B=0x07 -> Q=0xF2 (-14), R=0xFE (-2). A=0x64, B=0xF9 (-7) -> Q=0xF2, R=0x02. A=0x9C, B=0xF9 -> Q=0x0E, R=0xFE.
- A=0x25, B=0x00 -> Q=0xFF, R=0x25, div_by_zero=1, done 1 cycle after accept. The next op A=0x06, B=0x02 -> Q=0x03, R=0x00, div_by_zero=0.
- A=0x80 (-128), B=0xFF (-1) -> Q=0x80, R=0x00, ovf=1. A=0x80, B=0x01 -> Q=0x80, R=0x00, ovf=0.
- A=0x03, B=0x05 -> Q=0x00, R=0x03. Latency is 18 cycles without the macro and 1 cycle with DIVISION_CON_SIGNO_EARLY_EXIT_EN.
- Start A=0x09, B=0x03, pulse rst on cycle 5 -> no done pulse, all outputs 0. Re-issue the same op -> Q=0x03, R=0x00 after 18 cycles. A valid pulse issued mid-operation is ignored.
